// File: rtl/logic_fu_slot_if.sv
`default_nettype none
// ============================================================================
// Module      : logic_fu_slot_if
// Description : Operand/select request channel and result channel for one
//               logic functional-unit slot (two valid/ready handshakes).
// Revision    : 1.0 - initial release
// ============================================================================
interface logic_fu_slot_if #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 5
);
    // Request channel (issue lane -> slot)
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_sel;
    logic [TAG_W-1:0] in_tag;

    // Result channel (slot -> writeback)
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_zero;

    modport master (
        output in_valid, in_a, in_b, in_sel, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, out_zero
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sel, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, out_zero
    );
endinterface
`default_nettype wire

// File: rtl/logic_fu_slot.sv
`default_nettype none
// ============================================================================
// Module      : logic_fu_slot
// Description : Pipelined bitwise-logic functional unit for one VLIW lane.
//               Stage 1 captures operands, stage 2 registers the result,
//               then results queue in a FIFO. A credit counter bounds the
//               number of operations in flight so nothing is ever dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_fu_slot #(
    parameter int WIDTH      = 64,
    parameter int TAG_W      = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    logic_fu_slot_if.slave    bus,
    output logic [15:0]       ops_done
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] c_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] c_PONE  = PTR_W'(1);

    // Stage 1: captured operands
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [2:0]       r_s1_sel;
    logic [TAG_W-1:0] r_s1_tag;

    // Stage 2: registered result waiting to be written into the FIFO
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_res;
    logic [TAG_W-1:0] r_s2_tag;
    logic             r_s2_zero;

    // Result FIFO
    logic [WIDTH-1:0] r_fifo_res  [FIFO_DEPTH];
    logic [TAG_W-1:0] r_fifo_tag  [FIFO_DEPTH];
    logic             r_fifo_zero [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Last popped result, shown on the outputs while the FIFO is empty
    logic [WIDTH-1:0] r_last_res;
    logic [TAG_W-1:0] r_last_tag;
    logic             r_last_zero;

    logic [CNT_W-1:0] r_credit;
    logic [15:0]      r_ops_done;

    logic             w_accept;
    logic             w_pop;
    logic             w_nonempty;
    logic [WIDTH-1:0] w_res;

    assign w_nonempty   = (r_count != '0);
    assign bus.in_ready = (r_credit < c_DEPTH);
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_pop        = w_nonempty && bus.out_ready;

    assign bus.out_valid  = w_nonempty;
    assign bus.out_result = w_nonempty ? r_fifo_res[r_rd_ptr]  : r_last_res;
    assign bus.out_tag    = w_nonempty ? r_fifo_tag[r_rd_ptr]  : r_last_tag;
    assign bus.out_zero   = w_nonempty ? r_fifo_zero[r_rd_ptr] : r_last_zero;
    assign ops_done       = r_ops_done;

    // Stage-2 logic: select the bitwise function of the captured operands
    always_comb begin
        w_res = '0;
        case (r_s1_sel)
            3'd0:    w_res = r_s1_a & r_s1_b;
            3'd1:    w_res = r_s1_a | r_s1_b;
            3'd2:    w_res = r_s1_a ^ r_s1_b;
            3'd3:    w_res = ~(r_s1_a & r_s1_b);
            3'd4:    w_res = ~(r_s1_a | r_s1_b);
            3'd5:    w_res = ~(r_s1_a ^ r_s1_b);
            3'd6:    w_res = ~r_s1_a;
            default: w_res = r_s1_b;
        endcase
    end

    // Pipeline stages 1 and 2; operands only load on an accepted handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_sel   <= '0;
            r_s1_tag   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_res   <= '0;
            r_s2_tag   <= '0;
            r_s2_zero  <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_a   <= bus.in_a;
                r_s1_b   <= bus.in_b;
                r_s1_sel <= bus.in_sel;
                r_s1_tag <= bus.in_tag;
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_res  <= w_res;
                r_s2_tag  <= r_s1_tag;
                r_s2_zero <= (w_res == '0);
            end
        end
    end

    // FIFO storage: stage 2 writes the tail; no reset needed on the array
    always_ff @(posedge clk) begin
        if (!rst && r_s2_valid) begin
            r_fifo_res[r_wr_ptr]  <= r_s2_res;
            r_fifo_tag[r_wr_ptr]  <= r_s2_tag;
            r_fifo_zero[r_wr_ptr] <= r_s2_zero;
        end
    end

    // FIFO pointers, occupancy and the last-popped output hold registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_last_res  <= '0;
            r_last_tag  <= '0;
            r_last_zero <= 1'b0;
        end else begin
            if (r_s2_valid) begin
                r_wr_ptr <= r_wr_ptr + c_PONE;
            end
            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + c_PONE;
                r_last_res  <= r_fifo_res[r_rd_ptr];
                r_last_tag  <= r_fifo_tag[r_rd_ptr];
                r_last_zero <= r_fifo_zero[r_rd_ptr];
            end
            case ({r_s2_valid, w_pop})
                2'b10:   r_count <= r_count + c_ONE;
                2'b01:   r_count <= r_count - c_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Credits cover every op from acceptance until it is popped
    always_ff @(posedge clk) begin
        if (rst) begin
            r_credit <= '0;
        end else begin
            case ({w_accept, w_pop})
                2'b10:   r_credit <= r_credit + c_ONE;
                2'b01:   r_credit <= r_credit - c_ONE;
                default: r_credit <= r_credit;
            endcase
        end
    end

    // Saturating count of results handed to writeback
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ops_done <= '0;
        end else if (w_pop && (r_ops_done != 16'hFFFF)) begin
            r_ops_done <= r_ops_done + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_logic_fu_slot.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_fu_slot
// Description : Self-checking bench for logic_fu_slot: directed scenarios
//               plus random traffic against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_logic_fu_slot;

    localparam int WIDTH = 64;
    localparam int TAG_W = 5;
    localparam int DEPTH = 4;
    localparam logic [63:0] c_A = 64'h0000000FFC000070;
    localparam logic [63:0] c_B = 64'h71869861DEDE73BB;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ops_done;

    logic_fu_slot_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    logic_fu_slot #(.WIDTH(WIDTH), .TAG_W(TAG_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .ops_done (ops_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] res;
        logic [4:0]  tag;
        logic        zero;
    } exp_t;

    exp_t        q[$];
    int          credit;
    int          n_pop;
    logic [15:0] model_done;
    logic [63:0] by_tag [32];
    int          tests;
    int          fails;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_op(input logic [63:0] a, input logic [63:0] b,
                                           input logic [2:0] sel);
        case (sel)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a & b);
            3'd4:    return ~(a | b);
            3'd5:    return ~(a ^ b);
            3'd6:    return ~a;
            default: return b;
        endcase
    endfunction

    // One clock: starts and ends at a falling edge. Predicts handshakes,
    // checks the FIFO head against the model, then advances the model.
    task automatic cycle(input logic v, input logic [63:0] a, input logic [63:0] b,
                         input logic [2:0] sel, input logic [4:0] tag, input logic rdy,
                         output logic acc);
        logic pop;
        exp_t e;
        bus.in_valid  = v;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_sel    = sel;
        bus.in_tag    = tag;
        bus.out_ready = rdy;
        #1;
        check("in_ready", {63'd0, bus.in_ready}, {63'd0, credit < DEPTH});
        acc = v && bus.in_ready;
        pop = bus.out_valid && rdy;
        if (q.size() == 0) begin
            check("valid_when_empty", {63'd0, bus.out_valid}, 64'd0);
        end else if (bus.out_valid) begin
            check("head_result", bus.out_result, q[0].res);
            check("head_tag", {59'd0, bus.out_tag}, {59'd0, q[0].tag});
            check("head_zero", {63'd0, bus.out_zero}, {63'd0, q[0].zero});
        end
        if (pop && q.size() > 0) begin
            by_tag[q[0].tag] = bus.out_result;
            void'(q.pop_front());
            n_pop++;
            credit--;
            if (model_done != 16'hFFFF) model_done++;
        end
        if (acc) begin
            e.res  = ref_op(a, b, sel);
            e.tag  = tag;
            e.zero = (e.res == 64'd0);
            q.push_back(e);
            credit++;
        end
        @(posedge clk);
        @(negedge clk);
        check("ops_done", {48'd0, ops_done}, {48'd0, model_done});
    endtask

    task automatic idle(input logic rdy, input int n);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 64'd0, 64'd0, 3'd0, 5'd0, rdy, acc);
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        q.delete();
        credit     = 0;
        model_done = 16'd0;
        #1;
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        check("rst_ops_done", {48'd0, ops_done}, 64'd0);
        check("rst_out_result", bus.out_result, 64'd0);
        check("rst_out_tag", {59'd0, bus.out_tag}, 64'd0);
        check("rst_out_zero", {63'd0, bus.out_zero}, 64'd0);
    endtask

    initial begin
        logic acc;
        int idx;
        int pop0;
        logic [63:0] held;
        logic [63:0] pa [6];
        logic [63:0] pb [6];
        logic [2:0]  ps [6];

        tests = 0; fails = 0; credit = 0; n_pop = 0; model_done = 16'd0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
        bus.in_sel = '0; bus.in_tag = '0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        do_reset();

        // Single AND op and its two-edge latency
        cycle(1'b1, c_A, c_B, 3'd0, 5'd3, 1'b0, acc);
        check("and_accept", {63'd0, acc}, 64'd1);
        check("lat_edge0", {63'd0, bus.out_valid}, 64'd0);
        idle(1'b0, 1);
        check("lat_edge1", {63'd0, bus.out_valid}, 64'd0);
        idle(1'b0, 1);
        check("lat_edge2", {63'd0, bus.out_valid}, 64'd1);
        check("and_result", bus.out_result, 64'h00000001DC000030);
        check("and_tag", {59'd0, bus.out_tag}, 64'd3);
        check("and_zero", {63'd0, bus.out_zero}, 64'd0);
        idle(1'b1, 2);

        // Back-to-back sweep of all selects with writeback always ready
        do_reset();
        pop0 = n_pop;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, c_A, c_B, 3'(i), 5'(i), 1'b1, acc);
            check("sweep_accept", {63'd0, acc}, 64'd1);
        end
        idle(1'b1, 3);
        check("sweep_pops", 64'(n_pop - pop0), 64'd8);
        check("sweep_ops_done", {48'd0, ops_done}, 64'd8);
        check("sweep_and", by_tag[0], 64'h00000001DC000030);
        check("sweep_xor", by_tag[2], 64'h7186986E22DE73CB);
        check("sweep_nota", by_tag[6], 64'hFFFFFFF003FFFF8F);
        check("sweep_passb", by_tag[7], c_B);

        // Reset with three ops in flight; nothing stale may come out after
        for (int i = 0; i < 3; i++) cycle(1'b1, c_A, c_B, 3'(i), 5'(20 + i), 1'b0, acc);
        do_reset();
        idle(1'b1, 6);

        // Backpressure until full, then drain and accept the remainder
        for (int i = 0; i < 6; i++) begin
            pa[i] = {$urandom, $urandom};
            pb[i] = {$urandom, $urandom};
            ps[i] = 3'($urandom_range(0, 7));
        end
        idx = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, pa[idx], pb[idx], ps[idx], 5'(10 + idx), 1'b0, acc);
            if (acc) idx++;
        end
        check("full_accepted", 64'(idx), 64'd4);
        check("full_in_ready", {63'd0, bus.in_ready}, 64'd0);
        held = bus.out_result;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, pa[idx], pb[idx], ps[idx], 5'(10 + idx), 1'b0, acc);
            check("stall_stable", bus.out_result, held);
        end
        for (int t = 0; t < 30 && (idx < 6 || q.size() > 0); t++) begin
            if (idx < 6) begin
                cycle(1'b1, pa[idx], pb[idx], ps[idx], 5'(10 + idx), 1'b1, acc);
                if (acc) idx++;
            end else begin
                idle(1'b1, 1);
            end
        end
        check("full_all_accepted", 64'(idx), 64'd6);
        check("full_drained", 64'(q.size()), 64'd0);

        // Accept and pop on the same edge at credit == DEPTH-1
        for (int i = 0; i < 3; i++) cycle(1'b1, c_A, c_B, 3'(i + 3), 5'(i), 1'b0, acc);
        idle(1'b0, 2);
        check("sim_out_valid", {63'd0, bus.out_valid}, 64'd1);
        pop0 = n_pop;
        cycle(1'b1, c_B, c_A, 3'd1, 5'd7, 1'b1, acc);
        check("sim_accept", {63'd0, acc}, 64'd1);
        check("sim_popped", 64'(n_pop - pop0), 64'd1);
        check("sim_in_ready", {63'd0, bus.in_ready}, 64'd1);
        idle(1'b1, 8);
        check("sim_drained", 64'(q.size()), 64'd0);

        // Zero flag
        cycle(1'b1, 64'h5555555555555555, 64'h5555555555555555, 3'd2, 5'd9, 1'b0, acc);
        idle(1'b0, 2);
        check("zero_valid", {63'd0, bus.out_valid}, 64'd1);
        check("zero_result", bus.out_result, 64'd0);
        check("zero_flag", {63'd0, bus.out_zero}, 64'd1);
        idle(1'b1, 2);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
                  3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 3) != 0), acc);
        end
        for (int t = 0; t < 20 && q.size() > 0; t++) idle(1'b1, 1);
        check("rand_drained", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
